// File: rtl/ram_sync_nolatch_nrmw.sv
// ---------------------------------------------------------------------------
// ram_sync_nolatch_nrmw
//
// Parametrised multi-read / multi-write register-file RAM. Reads are
// combinational and writes happen on the clock edge. Write priority is fixed:
// the highest-numbered port wins. A register flags same-address write
// conflicts. After reset or on a clr request, a hardware sweep writes
// INIT_VAL into every entry. One debug read port follows the same read rules.
// The array itself has no reset; the sweep sets its contents.
//
// Optional build macro:
//   RAM_NOLATCH_BYPASS_EN - forwards same-cycle accepted write data to
//                           rdata/dbg_data (highest-numbered port wins).
//                           Without it, reads see the array as it was
//                           before the edge.
//
// Ports:
//   clk          clock, all state updates on posedge
//   reset_n      asynchronous active-low reset
//   clr          clear sweep request (level, sampled each cycle)
//   ready        sweep complete, writes accepted
//   raddr/rdata  NUM_RD read ports, port k at [k*W +: W]
//   waddr/wdata  NUM_WR write ports, same packing
//   we           per-port write enables
//   wr_conflict  one-cycle pulse after >=2 accepted writes hit one address
//   dbg_addr     debug read address
//   dbg_data     combinational debug read data
//
// FSM states:
//   state | meaning
//   SWEEP | writing INIT_VAL to mem[cnt], all writes ignored
//   READY | sweep done, normal write operation
// ---------------------------------------------------------------------------
`ifndef ADDR_LEN
`define ADDR_LEN 5
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module ram_sync_nolatch_nrmw #(
    parameter int                         BRAM_ADDR_WIDTH = `ADDR_LEN,
    parameter int                         BRAM_DATA_WIDTH = `DATA_LEN,
    parameter int                         DATA_DEPTH      = 32,
    parameter int                         NUM_RD          = 4,
    parameter int                         NUM_WR          = 2,
    parameter logic [BRAM_DATA_WIDTH-1:0] INIT_VAL        = '0,
    parameter bit                         ZERO_ENTRY0     = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               clr,
    output logic                               ready,
    input  logic [NUM_RD*BRAM_ADDR_WIDTH-1:0]  raddr,
    output logic [NUM_RD*BRAM_DATA_WIDTH-1:0]  rdata,
    input  logic [NUM_WR*BRAM_ADDR_WIDTH-1:0]  waddr,
    input  logic [NUM_WR*BRAM_DATA_WIDTH-1:0]  wdata,
    input  logic [NUM_WR-1:0]                  we,
    output logic                               wr_conflict,
    input  logic [BRAM_ADDR_WIDTH-1:0]         dbg_addr,
    output logic [BRAM_DATA_WIDTH-1:0]         dbg_data
);

    localparam int AW = BRAM_ADDR_WIDTH;
    localparam int DW = BRAM_DATA_WIDTH;
    localparam int CW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int NP = NUM_RD + 1;   // read ports plus the debug port
    localparam logic [CW-1:0] LAST    = CW'(DATA_DEPTH - 1);
    localparam logic [AW:0]   DEPTH_A = (AW + 1)'(DATA_DEPTH);

    typedef enum logic {SWEEP, READY} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   mem [DATA_DEPTH];

    logic [AW-1:0]   wa  [NUM_WR];
    logic [DW-1:0]   wd  [NUM_WR];
    logic [NUM_WR-1:0] acc;
    logic            conflict_c;

    logic [AW-1:0]   ra  [NP];
    logic [DW-1:0]   rv  [NP];

    // A write is accepted only while ready is high. That excludes the whole
    // sweep and the single settling cycle before ready rises. It also drops
    // out-of-range writes and writes to the hardwired zero entry.
    always_comb begin
        conflict_c = 1'b0;
        for (int p = 0; p < NUM_WR; p++) begin
            wa[p]  = waddr[p*AW +: AW];
            wd[p]  = wdata[p*DW +: DW];
            acc[p] = ready && we[p] && ({1'b0, wa[p]} < DEPTH_A)
                     && !(ZERO_ENTRY0 && (wa[p] == '0));
        end
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (acc[i] && acc[j] && (wa[i] == wa[j])) begin
                    conflict_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SWEEP;
            cnt         <= '0;
            ready       <= 1'b0;
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= conflict_c;
            case (state)
                SWEEP: begin
                    ready <= 1'b0;
                    if (clr) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state <= READY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    if (clr) begin
                        state <= SWEEP;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= SWEEP;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // The array has no reset. Ascending port order gives the
    // highest-numbered port the last assignment, so it wins.
    always_ff @(posedge clk) begin
        if (state == SWEEP) begin
            mem[cnt] <= INIT_VAL;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (acc[p]) begin
                    mem[wa[p][CW-1:0]] <= wd[p];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            ra[k] = raddr[k*AW +: AW];
        end
        ra[NUM_RD] = dbg_addr;
    end

    always_comb begin
        for (int k = 0; k < NP; k++) begin
            rv[k] = '0;
            if (!(ZERO_ENTRY0 && (ra[k] == '0)) && ({1'b0, ra[k]} < DEPTH_A)) begin
                rv[k] = mem[ra[k][CW-1:0]];
            end
`ifdef RAM_NOLATCH_BYPASS_EN
            // acc already excludes entry 0 and out-of-range addresses, so
            // forwarding never overrides the forced-zero or out-of-range reads.
            for (int p = 0; p < NUM_WR; p++) begin
                if (acc[p] && (wa[p] == ra[k])) begin
                    rv[k] = wd[p];
                end
            end
`endif
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rdata[k*DW +: DW] = rv[k];
        end
    end

    assign dbg_data = rv[NUM_RD];

endmodule

// File: tb/tb_ram_sync_nolatch_nrmw.sv
module tb_ram_sync_nolatch_nrmw;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NW = 2;

    logic              clk;
    logic              reset_n;
    logic              clr;
    logic              ready;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NW*AW-1:0]  waddr;
    logic [NW*DW-1:0]  wdata;
    logic [NW-1:0]     we;
    logic              wr_conflict;
    logic [AW-1:0]     dbg_addr;
    logic [DW-1:0]     dbg_data;

    int checks = 0;
    int errors = 0;

    ram_sync_nolatch_nrmw #(
        .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .DATA_DEPTH(32),
        .NUM_RD(NR), .NUM_WR(NW), .INIT_VAL(32'h0), .ZERO_ENTRY0(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .ready(ready),
        .raddr(raddr), .rdata(rdata), .waddr(waddr), .wdata(wdata), .we(we),
        .wr_conflict(wr_conflict), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
        waddr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
        we[p] = e;
    endtask

    task automatic set_all_raddr(input logic [AW-1:0] a);
        for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rd(input int k);
        return rdata[k*DW +: DW];
    endfunction

    // Waits out a full sweep that starts at the next edge: ready stays low
    // for 32 edges and rises on the 33rd.
    task automatic expect_sweep(input string name);
        int low_bad = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (ready !== 1'b0) low_bad++;
        end
        checks++;
        if (low_bad != 0) begin
            errors++;
            $display("FAIL %s_ready_low: %0d of 32 sweep cycles had ready high, required 0", name, low_bad);
        end
        tick();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_rise: ready=%b on 33rd edge, required 1", name, ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clr = 1'b0; we = '0; waddr = '0; wdata = '0;
        raddr = '0; dbg_addr = '0;
        #2;
        checks++;
        if (ready !== 1'b0 || wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b wr_conflict=%b, required 0/0", ready, wr_conflict);
        end
        tick(); tick();
        reset_n = 1'b1;
        expect_sweep("reset");
        for (int a = 0; a < 32; a++) begin
            dbg_addr = AW'(a);
            #1;
            checks++;
            if (dbg_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_clear_dbg: addr %0d read %h, required 0", a, dbg_data);
            end
        end
    endtask

    task automatic test_write_read();
        set_all_raddr(5'd5);
        set_wr(0, 5'd5, 32'hDEADBEEF, 1'b1);
        #1;
        checks++;
`ifdef RAM_NOLATCH_BYPASS_EN
        if (rd(0) !== 32'hDEADBEEF) begin
`else
        if (rd(0) !== 32'h0) begin
`endif
            errors++;
            $display("FAIL write_pre_edge: rdata0=%h before edge", rd(0));
        end
        tick();
        set_wr(0, 5'd0, 32'h0, 1'b0);
        #1;
        for (int k = 0; k < NR; k++) begin
            checks++;
            if (rd(k) !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL write_read_port%0d: got %h, required deadbeef", k, rd(k));
            end
        end
        set_wr(0, 5'd0, 32'h1, 1'b1);
        raddr[0 +: AW] = 5'd0;
        dbg_addr = 5'd0;
        tick();
        set_wr(0, 5'd0, 32'h0, 1'b0);
        #1;
        checks++;
        if (rd(0) !== 32'h0 || dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL zero_entry0: rdata0=%h dbg=%h, required 0", rd(0), dbg_data);
        end
    endtask

    task automatic test_conflict();
        set_wr(0, 5'd7, 32'h11, 1'b1);
        set_wr(1, 5'd7, 32'h22, 1'b1);
        set_all_raddr(5'd7);
        tick();
        we = '0;
        #1;
        checks++;
        if (rd(1) !== 32'h22) begin
            errors++;
            $display("FAIL conflict_priority: addr7 read %h, required 22", rd(1));
        end
        checks++;
        if (wr_conflict !== 1'b1) begin
            errors++;
            $display("FAIL conflict_pulse: wr_conflict=%b, required 1", wr_conflict);
        end
        tick();
        checks++;
        if (wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_one_cycle: wr_conflict=%b, required 0", wr_conflict);
        end
        // Distinct addresses: both land and there is no conflict.
        set_wr(0, 5'd8, 32'h88, 1'b1);
        set_wr(1, 5'd9, 32'h99, 1'b1);
        tick();
        we = '0;
        raddr[0 +: AW] = 5'd8;
        raddr[AW +: AW] = 5'd9;
        #1;
        checks++;
        if (wr_conflict !== 1'b0 || rd(0) !== 32'h88 || rd(1) !== 32'h99) begin
            errors++;
            $display("FAIL distinct_writes: conflict=%b r8=%h r9=%h, required 0/88/99", wr_conflict, rd(0), rd(1));
        end
        // Two writes to entry 0 are dropped, so they never count as a conflict.
        set_wr(0, 5'd0, 32'h5, 1'b1);
        set_wr(1, 5'd0, 32'h6, 1'b1);
        tick();
        we = '0;
        #1;
        checks++;
        if (wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL dropped_no_conflict: wr_conflict=%b, required 0", wr_conflict);
        end
    endtask

    task automatic test_reset_mid();
        reset_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_ready: ready=%b, required 0", ready);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL mid_sweep_reset: ready=%b conflict=%b, required 0/0", ready, wr_conflict);
        end
        tick();
        reset_n = 1'b1;
        expect_sweep("resweep");
        dbg_addr = 5'd7;
        raddr[0 +: AW] = 5'd8;
        #1;
        checks++;
        if (dbg_data !== 32'h0 || rd(0) !== 32'h0) begin
            errors++;
            $display("FAIL resweep_clear: addr7=%h addr8=%h, required 0", dbg_data, rd(0));
        end
    endtask

    task automatic test_clr();
        set_wr(0, 5'd3, 32'h55, 1'b1);
        tick();
        we = '0;
        raddr[0 +: AW] = 5'd3;
        #1;
        checks++;
        if (rd(0) !== 32'h55) begin
            errors++;
            $display("FAIL clr_prefill: addr3=%h, required 55", rd(0));
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        // Writes to addr3 during the whole sweep must be dropped.
        set_wr(1, 5'd3, 32'h77, 1'b1);
        begin
            int low_bad = 0;
            for (int i = 1; i <= 32; i++) begin
                if (ready !== 1'b0) low_bad++;
                tick();
            end
            checks++;
            if (low_bad != 0) begin
                errors++;
                $display("FAIL clr_ready_low: %0d cycles high, required 0", low_bad);
            end
        end
        we = '0;
        tick();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_ready_rise: ready=%b, required 1", ready);
        end
        dbg_addr = 5'd3;
        #1;
        checks++;
        if (rd(0) !== 32'h0 || dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL clr_cleared: addr3 rdata=%h dbg=%h, required 0", rd(0), dbg_data);
        end
    endtask

    task automatic test_bypass();
        raddr[2*AW +: AW] = 5'd9;
        dbg_addr = 5'd9;
        set_wr(0, 5'd9, 32'hCAFE, 1'b1);
        #1;
        checks++;
`ifdef RAM_NOLATCH_BYPASS_EN
        if (rd(2) !== 32'hCAFE || dbg_data !== 32'hCAFE) begin
`else
        if (rd(2) !== 32'h0 || dbg_data !== 32'h0) begin
`endif
            errors++;
            $display("FAIL rdw_same_cycle: rdata2=%h dbg=%h", rd(2), dbg_data);
        end
        tick();
        we = '0;
        #1;
        checks++;
        if (rd(2) !== 32'hCAFE) begin
            errors++;
            $display("FAIL rdw_after_edge: rdata2=%h, required cafe", rd(2));
        end
        set_wr(0, 5'd9, 32'h1111, 1'b1);
        set_wr(1, 5'd9, 32'h2222, 1'b1);
        #1;
        checks++;
`ifdef RAM_NOLATCH_BYPASS_EN
        if (rd(2) !== 32'h2222) begin
`else
        if (rd(2) !== 32'hCAFE) begin
`endif
            errors++;
            $display("FAIL rdw_two_ports: rdata2=%h", rd(2));
        end
        tick();
        we = '0;
        #1;
        checks++;
        if (rd(2) !== 32'h2222 || wr_conflict !== 1'b1) begin
            errors++;
            $display("FAIL rdw_two_ports_after: rdata2=%h conflict=%b, required 2222/1", rd(2), wr_conflict);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_conflict();
        test_reset_mid();
        test_clr();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_sync_nolatch_nrmw.md
Name: ram_sync_nolatch_nrmw

Overview:
- Parametrised multi-read/multi-write register-file RAM; successor to the fixed 2r1w/2r2w/4r2w RAMs used for the architectural register file, rename tables and ROB payload.
- Adds:
  - configurable port counts on flattened buses;
  - deterministic write priority;
  - conflict flagging;
  - a hardware clear sweep after reset or on request;
  - a single debug read port in place of per-entry outputs.
- Memory array itself is not reset; contents are established by the clear sweep.

Parameters:
- BRAM_ADDR_WIDTH, `ADDR_LEN, address width per port
- BRAM_DATA_WIDTH, `DATA_LEN, data width per entry
- DATA_DEPTH, 32, number of entries; must be <= 2**BRAM_ADDR_WIDTH
- NUM_RD, 4, read ports (1..8)
- NUM_WR, 2, write ports (1..4)
- INIT_VAL, 0, value written to every entry by the clear sweep
- ZERO_ENTRY0, 1, when 1 entry 0 always reads 0 and ignores writes

Ports:
- clk  in  1  clock, all state updates on posedge
- reset_n  in  1  asynchronous active-low reset
- clr  in  1  request a clear sweep (level; sampled each cycle)
- ready  out  1  high when sweep is complete and writes are accepted
- raddr  in  NUM_RD*BRAM_ADDR_WIDTH  read addresses, port k at bits [k*AW +: AW]
- rdata  out  NUM_RD*BRAM_DATA_WIDTH  read data, same packing
- waddr  in  NUM_WR*BRAM_ADDR_WIDTH  write addresses
- wdata  in  NUM_WR*BRAM_DATA_WIDTH  write data
- we  in  NUM_WR  per-port write enables
- wr_conflict  out  1  registered; high for one cycle after a cycle with two or more accepted writes to the same address
- dbg_addr  in  BRAM_ADDR_WIDTH  debug read address
- dbg_data  out  BRAM_DATA_WIDTH  combinational debug read data

Behaviour:
- FSM states: SWEEP, READY.
  - reset_n low: state=SWEEP, sweep counter=0, ready=0, wr_conflict=0, asynchronously.
- SWEEP:
  - each cycle writes INIT_VAL to mem[counter] and increments the counter.
  - all we ignored while in SWEEP.
  - when counter==DATA_DEPTH-1 the final write occurs and next state is READY.
  - sweep takes exactly DATA_DEPTH cycles; ready rises on the following edge.
- READY:
  - ready=1.
  - clr=1 sampled: next state SWEEP, counter=0; writes in that cycle are still performed.
  - clr=1 during SWEEP restarts the counter at 0.
- Reset mid-sweep or mid-operation: sweep restarts from 0; array contents undefined until the sweep completes.
- Reads:
  - combinational, rdata[k]=mem[raddr[k]], valid in every state.
  - during SWEEP, reads return current array contents (partially cleared).
  - raddr >= DATA_DEPTH: returns 0.
  - ZERO_ENTRY0=1: address 0 always returns 0.
- Writes (READY only):
  - on posedge, each port with we=1 and waddr<DATA_DEPTH updates its entry.
  - out-of-range or (ZERO_ENTRY0 and addr 0) writes are dropped.
  - same-address writes: highest-numbered port wins; wr_conflict=1 next cycle.
  - dropped writes never count toward a conflict.
- Read-during-write, no bypass: rdata shows the old value until the edge, the new value after.
- dbg_data uses the same read rules as rdata.

Optional Feature:
- RAM_NOLATCH_BYPASS_EN defined:
  - in READY, rdata[k] forwards wdata from the highest-numbered accepted write port whose waddr==raddr[k] in the same cycle (combinational write-to-read bypass).
  - applies also to dbg_data.
  - ZERO_ENTRY0 still forces 0.
- Undefined: no forwarding; reads see the pre-edge array.

Test Plan:
- Reset release, DEPTH=32, INIT_VAL=0 -> ready=0 for 32 cycles, 1 on the 33rd edge; all 32 entries read 0 via dbg.
- Write port0 addr5 data 0xDEADBEEF -> next cycle rdata[0..3] at addr5 = 0xDEADBEEF; addr0 write 0x1 -> still reads 0.
- Same cycle port0 addr7 0x11, port1 addr7 0x22 -> addr7 reads 0x22; wr_conflict pulses exactly 1 cycle.
- clr pulse after filling addr3=0x55 -> ready low 32 cycles; writes issued during the sweep are dropped; addr3 reads 0 after ready.
- Assert reset_n low at sweep count 10 -> ready=0 immediately; full 32-cycle sweep repeats.
- Bypass build: write addr9 0xCAFE while raddr[2]=9 -> rdata[2]=0xCAFE same cycle. Non-bypass build: old value, then 0xCAFE after the edge.
